// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage. Issues loads/stores on a
// req/addr_ok/data_ok data bus, aligns and extends load data, builds store
// strobes, flags address errors and stalls upstream until the bus completes.
//
// Bus handshake: the master holds data_req_o high with the request fields
// (addr, wr, size, wstrb, wdata) frozen until a cycle in which data_addr_ok_i
// is high; that cycle accepts the request. Exactly one response follows: the
// first later (or same) cycle with data_data_ok_i high completes it and, for
// loads, carries data_rdata_i. No second request is issued before data_ok.
// The instruction is expected to stay on the stage inputs from the issue
// cycle until the DONE cycle; stall_req_o covers REQ, WAIT and DRAIN.
module mem_access (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        hilo_we_i,
    input  logic [63:0] hilo_i,
    input  logic [31:0] exception_type_i,
    input  logic [31:0] current_instr_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic        flush_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    output logic [3:0]  data_wstrb_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic        stall_req_o,
    output logic        valid_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        hilo_we_o,
    output logic [63:0] hilo_o,
    output logic [31:0] exception_type_o,
    output logic [31:0] current_instr_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic [2:0]  fsm_state_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic [2:0]  state_q;
    logic [2:0]  state_d;
    logic [31:0] rdata_q;
    logic        capture;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        addr_err;
    logic        active;

    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;

    assign is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
    assign is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);

    // Alignment check: halfword ops need bit 0 clear, word ops both low bits.
    always_comb begin
        misaligned = 1'b0;
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: misaligned = addr_i[0];
            OP_LW, OP_SW:         misaligned = |addr_i[1:0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign addr_err = valid_i && misaligned;
    assign active   = valid_i && (is_load || is_store) && (exception_type_i == 32'd0)
                      && !addr_err && !flush_i;

    // Next-state logic, including flush withdrawal/drain and the combined
    // addr_ok+data_ok case.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (active) state_d = S_REQ;
            end
            S_REQ: begin
                if (flush_i) begin
                    if (!data_addr_ok_i)     state_d = S_IDLE;
                    else if (data_data_ok_i) state_d = S_IDLE;
                    else                     state_d = S_DRAIN;
                end else if (data_addr_ok_i) begin
                    if (data_data_ok_i) begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = data_data_ok_i ? S_IDLE : S_DRAIN;
                end else if (data_data_ok_i) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (data_data_ok_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and captured read word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (capture) rdata_q <= data_rdata_i;
        end
    end

    // Store encoding: size, byte strobes and replicated write data.
    always_comb begin
        bus_size  = 2'd0;
        bus_wstrb = 4'b0000;
        bus_wdata = 32'd0;
        case (mem_op_i)
            OP_LB, OP_LBU: bus_size = 2'd0;
            OP_LH, OP_LHU: bus_size = 2'd1;
            OP_LW:         bus_size = 2'd2;
            OP_SB: begin
                bus_size  = 2'd0;
                bus_wstrb = 4'b0001 << addr_i[1:0];
                bus_wdata = {4{store_data_i[7:0]}};
            end
            OP_SH: begin
                bus_size  = 2'd1;
                bus_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
                bus_wdata = {2{store_data_i[15:0]}};
            end
            OP_SW: begin
                bus_size  = 2'd2;
                bus_wstrb = 4'b1111;
                bus_wdata = store_data_i;
            end
            default: begin
                bus_size  = 2'd0;
                bus_wstrb = 4'b0000;
                bus_wdata = 32'd0;
            end
        endcase
    end

    // Load extraction from the captured word, then sign/zero extension.
    always_comb begin
        case (addr_i[1:0])
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = addr_i[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (mem_op_i)
            OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_data = {24'd0, ld_byte};
            OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_data = {16'd0, ld_half};
            OP_LW:   load_data = rdata_q;
            default: load_data = 32'd0;
        endcase
    end

    // Output drive; everything is forced low while reset is held.
    always_comb begin
        data_req_o           = 1'b0;
        data_wr_o            = 1'b0;
        data_size_o          = 2'd0;
        data_addr_o          = 32'd0;
        data_wdata_o         = 32'd0;
        data_wstrb_o         = 4'b0000;
        stall_req_o          = 1'b0;
        valid_o              = 1'b0;
        wd_o                 = 5'd0;
        wreg_o               = 1'b0;
        wdata_o              = 32'd0;
        hilo_we_o            = 1'b0;
        hilo_o               = 64'd0;
        exception_type_o     = 32'd0;
        current_instr_addr_o = 32'd0;
        is_in_delayslot_o    = 1'b0;
        badvaddr_o           = 32'd0;
        fsm_state_o          = S_IDLE;
        if (!rst_i) begin
            data_req_o   = (state_q == S_REQ);
            data_wr_o    = is_store;
            data_size_o  = bus_size;
            data_addr_o  = addr_i;
            data_wdata_o = bus_wdata;
            data_wstrb_o = bus_wstrb;
            stall_req_o  = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN);
            valid_o      = valid_i && !flush_i && (state_q != S_DRAIN);
            wd_o         = wd_i;
            wreg_o       = wreg_i && valid_o;
            wdata_o      = ((state_q == S_DONE) && is_load) ? load_data : wdata_i;
            hilo_we_o    = hilo_we_i && valid_o;
            hilo_o       = hilo_i;
            exception_type_o = exception_type_i;
            if (addr_err) begin
                exception_type_o = exception_type_i | (is_load ? 32'h0000_0010 : 32'h0000_0020);
                badvaddr_o       = addr_i;
            end
            current_instr_addr_o = current_instr_addr_i;
            is_in_delayslot_o    = is_in_delayslot_i;
            fsm_state_o          = state_q;
        end
    end

endmodule
